ham_chan: RTL and testbench
===========================

# ham_chan

Sequential noisy-channel model placed between `ham_enc` and `ham_dec` in the Hamming test path. It accepts one 17-bit codeword at a time and flips exactly `n_err` distinct bit positions, chosen by an internal LFSR. It then presents the corrupted word with its error mask so `ham_dec` and `bit_com` can be exercised with controlled error weights. Valid/ready handshakes are used on both sides, and only one word is in flight at a time.

## Interface
- `CW_W`, 17, codeword width (bit positions 0..16)
- `SEED`, 16'hACE1, LFSR reset value; must be nonzero
- `clk` input 1: single clock, rising edge
- `rst` input 1: asynchronous, active-high reset
- `in_valid` input 1: codeword offered
- `in_ready` output 1: block can accept a codeword
- `in_cw` input CW_W: clean codeword from `ham_enc`
- `n_err` input 2: number of bits to flip (0..3); sampled with `in_cw`
- `out_valid` output 1: corrupted word available
- `out_ready` input 1: consumer accepts the word
- `out_cw` output CW_W: corrupted codeword to `ham_dec`
- `err_mask` output CW_W: flipped positions; equals `out_cw ^ in_cw`
- `err_cnt` output 2: number of flips applied; equals popcount(`err_mask`)

## Operation
- FSM states: IDLE, INJECT, HOLD.
- **IDLE**
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid`, the accept edge:
    - latch `in_cw` into the working word and latch `n_err`.
    - clear `err_mask` and `err_cnt`.
    - go to HOLD if `n_err`=0, otherwise go to INJECT.
- **INJECT**, every cycle:
  - Candidate position `pos` = `lfsr[4:0]`, minus 17 when `lfsr[4:0]`≥17. This gives a range of 0..16.
  - If `err_mask[pos]`=0: set `err_mask[pos]`, invert working bit `pos`, and increment `err_cnt`.
  - If `err_mask[pos]`=1 (collision): make no change and retry next cycle.
  - Go to HOLD on the edge where the incremented `err_cnt` equals the latched `n_err`.
  - The LFSR steps once per INJECT cycle, collision or not.
- **HOLD**
  - `out_valid`=1; `out_cw`, `err_mask` and `err_cnt` are stable.
  - On `out_ready`, return to IDLE.
- **LFSR**: 16-bit Galois, right shift. Step rule: `lsb=lfsr[0]`; `lfsr=lfsr>>1`; if `lsb`, `lfsr^=16'hB400`.
  - The LFSR holds its value outside INJECT.
  - It is not reseeded between words; the sequence continues across words.
- `in_ready` is high only in IDLE, so input and output never overlap.
- No combinational path from `in_*` to `out_*`.
- Outputs are registered.
  - `out_cw`, `err_mask` and `err_cnt` show working values in INJECT.
  - Consumers use them only while `out_valid`=1.

## Timing
- **Reset** (asynchronous, any state, including mid-INJECT or mid-HOLD):
  - state=IDLE, `in_ready`=1, `out_valid`=0.
  - `out_cw`=0, `err_mask`=0, `err_cnt`=0, `lfsr`=`SEED`.
  - Any pending word is discarded.
- **Latency**, counted from the accept edge, with k=`n_err` and c = number of collision cycles:
  - k=0: `out_valid` is high in the first cycle after the accept edge.
  - k>0: `out_valid` rises k+c+1 cycles after the accept edge.
- `out_ready` held high in HOLD gives one HOLD cycle. The next `in_valid` can be accepted on the cycle after that.
- Throughput without stall is one word per k+c+2 cycles.
- `out_valid` and its data remain asserted indefinitely while `out_ready`=0.
- `in_valid` while `in_ready`=0 is ignored; the upstream must hold it.

## Structure
- Shared package `ham_pkg`:
  - `CW_W`=17, `INFO_W`=12.
  - LFSR tap constant 16'hB400.
  - FSM state typedef (IDLE/INJECT/HOLD).
- One sub-module, `ham_lfsr`:
  - ports: `clk`, `rst`, `en`, `SEED` parameter, 16-bit `state` output.
  - instantiated once; the mod-17 mapping stays in `ham_chan`.

## Test plan
- Reset, then `in_cw`=17'h0 with `n_err`=2 → accept edge T. Flip at bit 1 (`lfsr` 16'hACE1), then bit 16 (`lfsr` 16'hE270). `out_valid` high in cycle T+3 with `out_cw`=`err_mask`=17'h10002 and `err_cnt`=2.
- `in_cw`=17'h0A75, `n_err`=0 → `out_valid` one cycle after accept, `out_cw`=17'h0A75, `err_mask`=0, `err_cnt`=0, LFSR unchanged.
- 1000 random words with random `n_err` → each output satisfies `out_cw^in_cw`=`err_mask` and popcount(`err_mask`)=`err_cnt`=`n_err`. With `n_err`≤1, `ham_dec` recovers the info bits and `bit_com` reports `ham_dis`=0.
- Hold `out_ready`=0 for 10 cycles in HOLD → outputs stable and `in_ready`=0 throughout. Release → IDLE next cycle; the next word is accepted normally.
- Assert `rst` mid-INJECT of an `n_err`=3 word → all outputs return to 0 immediately and `in_ready`=1. The repeated stimulus of the first scenario reproduces 17'h10002.
- Collision coverage: run until `pos` repeats within one word → that cycle leaves the mask unchanged, `err_cnt` does not increment, and latency extends by exactly one cycle.

Source files
------------

// File: rtl/ham_pkg.sv
// Shared constants and types for the Hamming test path.
package ham_pkg;

    localparam int unsigned CW_W   = 17;
    localparam int unsigned INFO_W = 12;
    localparam int unsigned LFSR_W = 16;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned POS_W  = 5;

    // Galois feedback taps for the right-shifting 16-bit LFSR
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INJECT = 2'd1,
        HOLD   = 2'd2
    } chan_state_t;

endpackage

// File: rtl/ham_lfsr.sv
// 16-bit right-shifting Galois LFSR; advances only while en is high.
module ham_lfsr
    import ham_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [LFSR_W-1:0] state
);

    // Shift right and fold the taps back in when a one falls out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEED;
        end else if (en) begin
            state <= (state >> 1) ^ (state[0] ? LFSR_TAPS : LFSR_W'(0));
        end
    end

endmodule

// File: rtl/ham_chan.sv
// Noisy-channel model: flips exactly n_err distinct codeword bits per word.
module ham_chan
    import ham_pkg::*;
#(
    parameter int unsigned       CW_W = 17,
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CW_W-1:0]  in_cw,
    input  logic [CNT_W-1:0] n_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW_W-1:0]  out_cw,
    output logic [CW_W-1:0]  err_mask,
    output logic [CNT_W-1:0] err_cnt
);

    chan_state_t       state;
    chan_state_t       state_next;
    logic [LFSR_W-1:0] lfsr;
    logic [POS_W-1:0]  raw_c;
    logic [POS_W-1:0]  pos_c;
    logic [CW_W-1:0]   flip_c;
    logic              hit_c;
    logic              done_c;
    logic              accept_c;
    logic              lfsr_en_c;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic [CNT_W-1:0]  n_lat;
    logic              in_ready_d;
    logic              out_valid_d;

    ham_lfsr #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (lfsr_en_c),
        .state (lfsr)
    );

    // Candidate bit position folded into 0..CW_W-1, and whether it is still unused
    always_comb begin
        raw_c     = lfsr[POS_W-1:0];
        pos_c     = (raw_c >= POS_W'(CW_W)) ? (raw_c - POS_W'(CW_W)) : raw_c;
        flip_c    = CW_W'(1) << pos_c;
        hit_c     = ((err_mask & flip_c) == CW_W'(0));
        cnt_inc_c = err_cnt + CNT_W'(1);
        done_c    = hit_c && (cnt_inc_c == n_lat);
        accept_c  = (state == IDLE) && in_valid;
        lfsr_en_c = (state == INJECT);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = (n_err == CNT_W'(0)) ? HOLD : INJECT;
            INJECT:  if (done_c) state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the upcoming state so they can be registered
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        case (state_next)
            IDLE:    in_ready_d  = 1'b1;
            HOLD:    out_valid_d = 1'b1;
            default: ;
        endcase
    end

    // Registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

    // Working word: load on accept, flip one fresh position per successful INJECT cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cw   <= CW_W'(0);
            err_mask <= CW_W'(0);
            err_cnt  <= CNT_W'(0);
            n_lat    <= CNT_W'(0);
        end else if (accept_c) begin
            out_cw   <= in_cw;
            err_mask <= CW_W'(0);
            err_cnt  <= CNT_W'(0);
            n_lat    <= n_err;
        end else if ((state == INJECT) && hit_c) begin
            out_cw   <= out_cw ^ flip_c;
            err_mask <= err_mask | flip_c;
            err_cnt  <= cnt_inc_c;
        end
    end

endmodule

// File: tb/tb_ham_chan.sv
// Directed bench for ham_chan: hand-computed LFSR walk, stall, reset and collision cases.
module tb_ham_chan;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] in_cw;
    logic [1:0]  n_err;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_cw;
    logic [16:0] err_mask;
    logic [1:0]  err_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;
    logic [1:0]  hist_cnt  [8];
    logic [16:0] hist_mask [8];

    always #5 clk = ~clk;

    ham_chan #(.CW_W(17), .SEED(16'hACE1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cw     (in_cw),
        .n_err     (n_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cw    (out_cw),
        .err_mask  (err_mask),
        .err_cnt   (err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one word, then count cycles until out_valid (bounded)
    task automatic send_word(input logic [16:0] cw, input logic [1:0] n, output int latency);
        int l;
        @(negedge clk);
        in_valid = 1'b1;
        in_cw    = cw;
        n_err    = n;
        @(posedge clk);
        #1 in_valid = 1'b0;
        l = 0;
        do begin
            @(negedge clk);
            l++;
            if (l < 8) begin
                hist_cnt[l]  = err_cnt;
                hist_mask[l] = err_mask;
            end
        end while (!out_valid && l < 50);
        latency = l;
    endtask

    // Accept the output for one cycle and confirm the return to IDLE
    task automatic finish_word(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    task automatic check_word(input string tag, input int l, input int l_exp,
                              input logic [16:0] cw_exp, input logic [16:0] mask_exp,
                              input logic [1:0] cnt_exp);
        check({tag, "_latency"}, 32'(l), 32'(l_exp));
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_out_cw"}, 32'(out_cw), 32'(cw_exp));
        check({tag, "_err_mask"}, 32'(err_mask), 32'(mask_exp));
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'(cnt_exp));
    endtask

    initial begin
        logic [16:0] rcw;
        logic [1:0]  rn;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_cw     = '0;
        n_err     = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_cw", 32'(out_cw), 32'd0);
        check("rst_err_mask", 32'(err_mask), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;

        // LFSR ACE1 -> bit 1, E270 -> bit 16
        send_word(17'h00000, 2'd2, lat);
        check_word("wA", lat, 3, 17'h10002, 17'h10002, 2'd2);
        finish_word("wA");

        // Zero errors: pass-through, LFSR untouched
        send_word(17'h00A75, 2'd0, lat);
        check_word("wB", lat, 1, 17'h00A75, 17'h00000, 2'd0);
        finish_word("wB");

        // LFSR 7138 -> 7, 389C -> 11, 1C4E -> 14
        send_word(17'h1FFFF, 2'd3, lat);
        check_word("wC", lat, 4, 17'h1B77F, 17'h04880, 2'd3);

        // Stall in HOLD; a new offer must be ignored
        in_valid = 1'b1;
        in_cw    = 17'h15555;
        n_err    = 2'd1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_cw", 32'(out_cw), 32'h1B77F);
            check("hold_err_mask", 32'(err_mask), 32'h04880);
        end
        in_valid = 1'b0;
        finish_word("wC");

        // 0E27 -> 7, B313 -> 2, ED89 -> 9
        send_word(17'h12345, 2'd3, lat);
        check_word("wD", lat, 4, 17'h121C1, 17'h00284, 2'd3);
        finish_word("wD");

        // C2C4 -> 4, 6162 -> 2, 30B1 -> 0
        send_word(17'h1AAAA, 2'd3, lat);
        check_word("wE", lat, 4, 17'h1AABF, 17'h00015, 2'd3);
        finish_word("wE");

        // AC58 -> 7, 562C -> 12
        send_word(17'h05555, 2'd2, lat);
        check_word("wF", lat, 3, 17'h045D5, 17'h01080, 2'd2);
        finish_word("wF");

        // 2B16 -> 5, 158B -> 11, BEC5 -> 5 (collision), EB62 -> 2
        send_word(17'h00000, 2'd3, lat);
        check_word("wG", lat, 5, 17'h00824, 17'h00824, 2'd3);
        check("wG_cnt_c2", 32'(hist_cnt[2]), 32'd1);
        check("wG_cnt_c3", 32'(hist_cnt[3]), 32'd2);
        check("wG_cnt_collide", 32'(hist_cnt[4]), 32'd2);
        check("wG_mask_collide", 32'(hist_mask[4]), 32'h00820);
        finish_word("wG");

        // Asynchronous reset in the middle of an INJECT sequence
        @(negedge clk);
        in_valid = 1'b1;
        in_cw    = 17'h1FFFF;
        n_err    = 2'd3;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_cw", 32'(out_cw), 32'd0);
        check("mid_rst_err_mask", 32'(err_mask), 32'd0);
        check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reseeded LFSR reproduces the first word
        send_word(17'h00000, 2'd2, lat);
        check_word("wA2", lat, 3, 17'h10002, 17'h10002, 2'd2);
        finish_word("wA2");

        // Random words: structural invariants only
        for (int i = 0; i < 20; i++) begin
            rcw = 17'($urandom);
            rn  = 2'($urandom_range(0, 3));
            send_word(rcw, rn, lat);
            check("rnd_out_valid", 32'(out_valid), 32'd1);
            check("rnd_mask_xor", 32'(out_cw ^ rcw), 32'(err_mask));
            check("rnd_popcount", 32'($countones(err_mask)), 32'(rn));
            check("rnd_err_cnt", 32'(err_cnt), 32'(rn));
            finish_word("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
